vga_theme_seq: RTL and testbench
================================

Name: vga_theme_seq

Overview:
Multi-theme sequencer for the VGA pipeline. It generalises the single-bit theme toggle to NUM_THEMES themes with forward/backward stepping, direct select, and optional timed auto-cycling. Theme changes are queued and committed only on a frame boundary (frame_start pulse), so the pixel generator never switches palette mid-frame. It sits between the button/switch front end and the VGA pixel/colour logic.

Parameters:
NUM_THEMES, 4, number of valid themes (2..2**THEME_W); legal values 0..NUM_THEMES-1
THEME_W, 2, width of theme index
AUTO_FRAMES, 60, frames between auto-advances (used only with THEME_AUTO_EN); must be >= 1
CNT_W, 8, width of auto frame counter; must hold AUTO_FRAMES-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
chg  in  1  step request, level (debounced upstream); acts on rising edge only
dir  in  1  step direction sampled with the chg edge: 0 = next (+1), 1 = previous (-1)
load  in  1  direct-select strobe, single-cycle
sel  in  THEME_W  theme index for load
auto_on  in  1  auto-cycle enable (ignored without THEME_AUTO_EN)
frame_start  in  1  single-cycle pulse at start of vertical blank
theme  out  THEME_W  committed theme index
pending  out  1  a change is queued, awaiting frame_start
theme_chg  out  1  single-cycle pulse in the cycle after theme updates

Behaviour:
- Reset (rst=1 at clk edge): theme=0, pending=0, theme_chg=0, queued target=0, chg edge register=0, auto counter=0. Reset wins over all other inputs, including mid-pending.
- chg edge detect: registered chg_d; step event = chg & ~chg_d. Holding chg high produces exactly one step.
- Target computation (base = queued target if pending else theme):
  - next: base==NUM_THEMES-1 -> 0, else base+1
  - prev: base==0 -> NUM_THEMES-1, else base-1
  - load: target=sel if sel<NUM_THEMES; if sel>=NUM_THEMES the load is ignored entirely (pending unchanged).
- Priority in the same cycle: load > step event > auto event. Only one source applies per cycle; the others are dropped.
- FSM, two states:
  - IDLE (pending=0): an accepted request writes the target register and moves to PEND. A target equal to the current theme is still queued (it causes no theme_chg later).
  - PEND (pending=1): further requests overwrite the target (steps accumulate from the queued target). On frame_start: theme<=target, go to IDLE.
  - A request arriving in the same cycle as frame_start in PEND: frame_start commits the old target first; the new request is computed from that committed value and queued, and the state stays PEND.
  - A request in IDLE in the same cycle as frame_start: it is queued only and commits at the next frame_start (minimum one full frame of latency).
- theme_chg: asserted exactly one cycle, in the cycle after commit, only if the new theme differs from the old one.
- Latency: request to theme update = cycles until the next frame_start + 1 edge.

Optional Feature:
THEME_AUTO_EN
- Defined: when auto_on=1, the counter increments on each frame_start. When it reaches AUTO_FRAMES-1 it wraps to 0 and raises an auto event (a "next" step, lowest priority). Any accepted load or chg step clears the counter. auto_on=0 holds the counter at 0.
- Undefined: no counter is built, auto_on is unused, and behaviour is manual only.

Test Plan:
- Reset then 3 chg edges with dir=0, frame_start after each -> theme 1, 2, 3; a 4th edge -> wraps to 0; theme_chg pulses 4 times.
- theme=0, chg edge with dir=1, then frame_start -> theme=3 (NUM_THEMES=4); pending goes 1 then 0.
- Hold chg high for 100 cycles, then frame_start -> theme advances by exactly 1.
- Two chg edges (dir=0) before one frame_start, theme=1 -> single commit to 3; a single theme_chg pulse.
- load with sel=2 and a chg edge in the same cycle -> theme=2 after frame_start. load with sel=5 (THEME_W=3, NUM_THEMES=5) -> ignored, pending stays 0.
- rst asserted while pending=1 -> theme=0, pending=0; the next frame_start causes no change. With THEME_AUTO_EN, AUTO_FRAMES=3, auto_on=1 -> theme advances once every 3 frame_starts.

Source files
------------

// File: rtl/vga_theme_seq.sv
// Multi-theme sequencer: queues step/load/auto requests and commits them on frame_start.
// Optional timed auto-cycling is built only when THEME_AUTO_EN is defined.
module vga_theme_seq #(
  parameter int unsigned NUM_THEMES  = 4,
  parameter int unsigned THEME_W     = 2,
  parameter int unsigned AUTO_FRAMES = 60,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_chg,
  input  logic               i_dir,
  input  logic               i_load,
  input  logic [THEME_W-1:0] i_sel,
  input  logic               i_auto_on,
  input  logic               i_frame_start,
  output logic [THEME_W-1:0] o_theme,
  output logic               o_pending,
  output logic               o_theme_chg
);

  localparam logic [THEME_W:0]   LP_NUM = (THEME_W+1)'(NUM_THEMES);
  localparam logic [THEME_W-1:0] LP_MAX = THEME_W'(NUM_THEMES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [THEME_W-1:0] r_theme, w_theme_nxt;
  logic [THEME_W-1:0] r_target, w_target_nxt;
  logic [THEME_W-1:0] w_base, w_new;
  logic               r_chg_d;
  logic               r_theme_chg, w_theme_chg_nxt;
  logic               w_step, w_load_ok, w_auto, w_req, w_commit;

  assign w_step    = i_chg & ~r_chg_d;
  assign w_load_ok = i_load & ({1'b0, i_sel} < LP_NUM);
  assign w_req     = w_load_ok | w_step | w_auto;

`ifdef THEME_AUTO_EN
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(AUTO_FRAMES - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_auto = i_auto_on & i_frame_start & (r_cnt == LP_CNT_MAX);

  // Frame counter; manual requests restart the interval
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_auto_on || w_load_ok || w_step)
      w_cnt_nxt = '0;
    else if (i_frame_start)
      w_cnt_nxt = (r_cnt == LP_CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nxt;
  end
`else
  logic w_unused_auto;
  assign w_unused_auto = i_auto_on ^ (^CNT_W'(AUTO_FRAMES));
  assign w_auto        = 1'b0;
`endif

  // Queued target is the base while pending; it equals the just-committed value on frame_start
  always_comb begin
    w_base = (r_state == S_PEND) ? r_target : r_theme;
    w_new  = (w_base == LP_MAX) ? '0 : w_base + THEME_W'(1);
    if (w_load_ok)
      w_new = i_sel;
    else if (w_step && i_dir)
      w_new = (w_base == '0) ? LP_MAX : w_base - THEME_W'(1);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_theme_nxt  = r_theme;
    w_target_nxt = r_target;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_target_nxt = w_new;
          w_state_nxt  = S_PEND;
        end
      end
      S_PEND: begin
        if (i_frame_start) begin
          w_commit    = 1'b1;
          w_theme_nxt = r_target;
          w_state_nxt = w_req ? S_PEND : S_IDLE;
        end
        if (w_req) w_target_nxt = w_new;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_theme_chg_nxt = w_commit && (r_target != r_theme);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_theme     <= '0;
      r_target    <= '0;
      r_chg_d     <= 1'b0;
      r_theme_chg <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_theme     <= w_theme_nxt;
      r_target    <= w_target_nxt;
      r_chg_d     <= i_chg;
      r_theme_chg <= w_theme_chg_nxt;
    end
  end

  assign o_theme     = r_theme;
  assign o_pending   = (r_state == S_PEND);
  assign o_theme_chg = r_theme_chg;

endmodule

// File: tb/tb_vga_theme_seq.sv
// Self-checking bench for vga_theme_seq: 4-theme main instance plus a 5-theme/3-bit instance.
module tb_vga_theme_seq;

  logic       clk = 1'b0;
  logic       rst, chg, dir, load, auto_on, fs;
  logic [1:0] sel;
  logic [1:0] theme;
  logic       pending, theme_chg;

  logic       chg5, dir5, load5, auto5, fs5;
  logic [2:0] sel5;
  logic [2:0] theme5;
  logic       pending5, theme_chg5;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int cur_theme = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  vga_theme_seq #(.NUM_THEMES(4), .THEME_W(2), .AUTO_FRAMES(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .i_chg(chg), .i_dir(dir), .i_load(load), .i_sel(sel),
    .i_auto_on(auto_on), .i_frame_start(fs),
    .o_theme(theme), .o_pending(pending), .o_theme_chg(theme_chg));

  vga_theme_seq #(.NUM_THEMES(5), .THEME_W(3), .AUTO_FRAMES(3), .CNT_W(8)) u_dut5 (
    .clk(clk), .rst(rst), .i_chg(chg5), .i_dir(dir5), .i_load(load5), .i_sel(sel5),
    .i_auto_on(auto5), .i_frame_start(fs5),
    .o_theme(theme5), .o_pending(pending5), .o_theme_chg(theme_chg5));

  always @(negedge clk) if (theme_chg) pulses++;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    cur_theme = 0;
  endtask

  task automatic pulse_chg(input logic d);
    chg = 1'b1; dir = d; cyc();
    chg = 1'b0; cyc();
  endtask

  // Scoreboarded frame: expected theme is pushed with the pulse and popped after the edge
  task automatic frame(input int exp);
    int got;
    exp_q.push_back(exp);
    fs = 1'b1; cyc(); fs = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (int'(theme) !== got) begin
      failures++; $display("FAIL frame_theme got=%0d exp=%0d", theme, got);
    end
    checks++;
    if (theme_chg !== (got != cur_theme)) begin
      failures++; $display("FAIL frame_theme_chg got=%0b exp=%0b", theme_chg, got != cur_theme);
    end
    cur_theme = got;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 3;
    if (theme !== 2'd0)    begin failures++; $display("FAIL reset_theme got=%0d exp=0", theme); end
    if (pending !== 1'b0)  begin failures++; $display("FAIL reset_pending got=%0b exp=0", pending); end
    if (theme_chg !== 1'b0) begin failures++; $display("FAIL reset_theme_chg got=%0b exp=0", theme_chg); end
  endtask

  task automatic test_forward();
    int p0 = pulses;
    for (int i = 1; i <= 4; i++) begin
      pulse_chg(1'b0);
      checks++;
      if (pending !== 1'b1) begin failures++; $display("FAIL fwd_pending got=%0b exp=1", pending); end
      frame(i % 4);
      checks++;
      if (pending !== 1'b0) begin failures++; $display("FAIL fwd_cleared got=%0b exp=0", pending); end
    end
    checks++;
    if (pulses - p0 !== 4) begin failures++; $display("FAIL fwd_pulses got=%0d exp=4", pulses - p0); end
  endtask

  task automatic test_prev_wrap();
    pulse_chg(1'b1);
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL prev_pending got=%0b exp=1", pending); end
    frame(3);
  endtask

  task automatic test_hold();
    chg = 1'b1; dir = 1'b0;
    repeat (100) cyc();
    chg = 1'b0; cyc();
    frame(0);
  endtask

  task automatic test_accumulate();
    int p0;
    pulse_chg(1'b0); frame(1);
    p0 = pulses;
    pulse_chg(1'b0); pulse_chg(1'b0);
    frame(3);
    checks++;
    if (pulses - p0 !== 1) begin failures++; $display("FAIL accum_pulses got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_load_priority();
    load = 1'b1; sel = 2'd2; chg = 1'b1; dir = 1'b0; cyc();
    load = 1'b0; chg = 1'b0; cyc();
    frame(2);
  endtask

  task automatic test_same_cycle();
    pulse_chg(1'b0);
    // PEND: commit 3 and queue 3+1 -> 0 in the same cycle
    exp_q.push_back(3);
    chg = 1'b1; dir = 1'b0; fs = 1'b1; cyc();
    chg = 1'b0; fs = 1'b0;
    checks += 2;
    if (int'(theme) !== exp_q.pop_front()) begin failures++; $display("FAIL pend_fs_theme got=%0d exp=3", theme); end
    if (pending !== 1'b1) begin failures++; $display("FAIL pend_fs_pending got=%0b exp=1", pending); end
    cur_theme = 3;
    cyc();
    frame(0);
    // IDLE: request with frame_start is only queued
    chg = 1'b1; fs = 1'b1; cyc();
    chg = 1'b0; fs = 1'b0;
    checks += 2;
    if (theme !== 2'd0)   begin failures++; $display("FAIL idle_fs_theme got=%0d exp=0", theme); end
    if (pending !== 1'b1) begin failures++; $display("FAIL idle_fs_pending got=%0b exp=1", pending); end
    cyc();
    frame(1);
  endtask

  task automatic test_load_range();
    load5 = 1'b1; sel5 = 3'd5; cyc(); load5 = 1'b0; cyc();
    checks++;
    if (pending5 !== 1'b0) begin failures++; $display("FAIL oob_pending got=%0b exp=0", pending5); end
    load5 = 1'b1; sel5 = 3'd4; cyc(); load5 = 1'b0;
    fs5 = 1'b1; cyc(); fs5 = 1'b0;
    checks += 2;
    if (theme5 !== 3'd4)     begin failures++; $display("FAIL load5_theme got=%0d exp=4", theme5); end
    if (theme_chg5 !== 1'b1) begin failures++; $display("FAIL load5_chg got=%0b exp=1", theme_chg5); end
    chg5 = 1'b1; dir5 = 1'b0; cyc(); chg5 = 1'b0;
    fs5 = 1'b1; cyc(); fs5 = 1'b0;
    checks++;
    if (theme5 !== 3'd0) begin failures++; $display("FAIL wrap5_theme got=%0d exp=0", theme5); end
  endtask

  task automatic test_reset_pending();
    pulse_chg(1'b0);
    checks++;
    if (pending !== 1'b1) begin failures++; $display("FAIL rstp_pre got=%0b exp=1", pending); end
    do_reset();
    checks += 2;
    if (theme !== 2'd0)   begin failures++; $display("FAIL rstp_theme got=%0d exp=0", theme); end
    if (pending !== 1'b0) begin failures++; $display("FAIL rstp_pending got=%0b exp=0", pending); end
    frame(0);
  endtask

  task automatic test_auto();
    int exp_seq[7];
`ifdef THEME_AUTO_EN
    exp_seq = '{0, 0, 0, 1, 1, 1, 2};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0, 0};
`endif
    do_reset();
    auto_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      frame(exp_seq[i]);
      repeat (3) cyc();
    end
    auto_on = 1'b0;
  endtask

  initial begin
    rst = 1'b1; chg = 1'b0; dir = 1'b0; load = 1'b0; sel = '0; auto_on = 1'b0; fs = 1'b0;
    chg5 = 1'b0; dir5 = 1'b0; load5 = 1'b0; sel5 = '0; auto5 = 1'b0; fs5 = 1'b0;
    test_reset();
    test_forward();
    test_prev_wrap();
    test_hold();
    test_accumulate();
    test_load_priority();
    test_same_cycle();
    test_load_range();
    test_reset_pending();
    test_auto();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
